// File: rtl/gtb_pkg.sv
// Shared types, constants and the Gray-to-binary decode for the Gray tracker.
package gtb_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } gtb_state_e;

  localparam int unsigned RESYNC_CNT          = 4;
  localparam int unsigned ERR_CNT_MAX         = 255;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Zero-extended inputs decode correctly because the upper Gray bits are 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gtb_if.sv
// Control, Gray input and tracking-result bundle of the Gray tracker.
interface gtb_if #(
  parameter int unsigned W = 4
);
  logic         en;
  logic         clr;
  logic [W-1:0] g_in;
  logic [W-1:0] bin_out;
  logic [15:0]  pos;
  logic         dir;
  logic         step_valid;
  logic         err;
  logic [7:0]   err_cnt;
  logic         trk;

  modport master (
    output en, clr, g_in,
    input  bin_out, pos, dir, step_valid, err, err_cnt, trk
  );

  modport slave (
    input  en, clr, g_in,
    output bin_out, pos, dir, step_valid, err, err_cnt, trk
  );
endinterface

// File: rtl/gtb_sync.sv
// Multi-flop synchronizer for the asynchronous Gray input, with a fill flag
// that marks when the last stage holds a real post-reset sample.
module gtb_sync #(
  parameter int unsigned W           = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_valid
);

  logic [SYNC_STAGES-1:0][W-1:0] r_stage;
  logic [SYNC_STAGES-1:0]        r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_vld   <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
      r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_q     = r_stage[SYNC_STAGES-1];
  assign o_valid = r_vld[SYNC_STAGES-1];

endmodule

// File: rtl/gtb_tracker.sv
// Gray-coded absolute position tracker: synchronizes, decodes, accumulates
// single-code steps into a signed position and recovers from illegal jumps.
module gtb_tracker
  import gtb_pkg::*;
#(
  parameter int unsigned W           = 4,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  gtb_if.slave  bus
);

  logic [W-1:0] w_sync;
  logic         w_sync_vld;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_delta;
  logic         w_up;
  logic         w_down;

  gtb_state_e   r_state, w_state_nxt;
  logic [W-1:0] r_prev_g, w_prev_g_nxt;
  logic [W-1:0] r_prev_b, w_prev_b_nxt;
  logic [W-1:0] r_bin, w_bin_nxt;
  logic [W-1:0] r_last, w_last_nxt;
  logic [15:0]  r_pos, w_pos_nxt;
  logic         r_dir, w_dir_nxt;
  logic         r_sv, w_sv_nxt;
  logic         r_err, w_err_nxt;
  logic [7:0]   r_err_cnt, w_err_cnt_nxt;
  logic [1:0]   r_stab, w_stab_nxt;
  logic         r_trk;

  gtb_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (bus.g_in),
    .o_q     (w_sync),
    .o_valid (w_sync_vld)
  );

  assign w_dec   = W'(gray2bin(32'(w_sync)));
  assign w_delta = w_dec - r_prev_b;
  assign w_up    = (w_delta == W'(1));
  assign w_down  = (w_delta == '1);

  always_comb begin
    w_state_nxt   = r_state;
    w_prev_g_nxt  = r_prev_g;
    w_prev_b_nxt  = r_prev_b;
    w_bin_nxt     = r_bin;
    w_last_nxt    = r_last;
    w_pos_nxt     = r_pos;
    w_dir_nxt     = r_dir;
    w_sv_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_stab_nxt    = r_stab;

    if (bus.clr) begin
      w_pos_nxt     = '0;
      w_err_cnt_nxt = '0;
      w_dir_nxt     = 1'b0;
      w_stab_nxt    = '0;
      w_state_nxt   = INIT;
    end else if (bus.en) begin
      unique case (r_state)
        INIT: begin
          if (w_sync_vld) begin
            w_prev_g_nxt = w_sync;
            w_prev_b_nxt = w_dec;
            w_bin_nxt    = w_dec;
            w_pos_nxt    = 16'(w_dec);
            w_state_nxt  = TRACK;
          end
        end
        TRACK: begin
          if (w_sync != r_prev_g) begin
            if (w_up || w_down) begin
              w_pos_nxt    = w_up ? r_pos + 16'd1 : r_pos - 16'd1;
              w_dir_nxt    = w_up;
              w_sv_nxt     = 1'b1;
              w_prev_g_nxt = w_sync;
              w_prev_b_nxt = w_dec;
              w_bin_nxt    = w_dec;
            end else begin
              w_err_nxt = 1'b1;
              if (r_err_cnt != 8'(ERR_CNT_MAX)) w_err_cnt_nxt = r_err_cnt + 8'd1;
              w_last_nxt  = w_sync;
              w_stab_nxt  = '0;
              w_state_nxt = ERROR;
            end
          end
        end
        ERROR: begin
          // The offending sample counts as the reference; four further equal samples resync.
          if (w_sync == r_last) begin
            if (r_stab == 2'(RESYNC_CNT - 1)) begin
              w_prev_g_nxt = w_sync;
              w_prev_b_nxt = w_dec;
              w_bin_nxt    = w_dec;
              w_stab_nxt   = '0;
              w_state_nxt  = TRACK;
            end else begin
              w_stab_nxt = r_stab + 2'd1;
            end
          end else begin
            w_last_nxt = w_sync;
            w_stab_nxt = '0;
          end
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT;
      r_prev_g  <= '0;
      r_prev_b  <= '0;
      r_bin     <= '0;
      r_last    <= '0;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_sv      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_stab    <= '0;
      r_trk     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev_g  <= w_prev_g_nxt;
      r_prev_b  <= w_prev_b_nxt;
      r_bin     <= w_bin_nxt;
      r_last    <= w_last_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_sv      <= w_sv_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_stab    <= w_stab_nxt;
      r_trk     <= (w_state_nxt == TRACK);
    end
  end

  assign bus.bin_out    = r_bin;
  assign bus.pos        = r_pos;
  assign bus.dir        = r_dir;
  assign bus.step_valid = r_sv;
  assign bus.err        = r_err;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.trk        = r_trk;

endmodule

// File: tb/tb_gtb_tracker.sv
// Bench for gtb_tracker: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the tracking rules.
module tb_gtb_tracker;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int M  = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gtb_if #(.W(W)) bus ();

  gtb_tracker #(.W(W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_b = 0;

  // model state: mode 0 = waiting for first sample, 1 = tracking, 2 = recovering
  int m_pipe[SS];
  int m_fill, m_mode, m_prev_b, m_bin, m_pos, m_dir, m_sv, m_er, m_errc, m_trk;
  int m_stable, m_last;

  function automatic int g2b(int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & (M - 1);
  endfunction

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & (M - 1);
  endfunction

  function automatic logic [31:0] mvec();
    return {W'(m_bin), 16'(m_pos), m_dir[0], m_sv[0], m_er[0], 8'(m_errc), m_trk[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_pipe[i] = 0;
    m_fill = 0; m_mode = 0; m_prev_b = 0; m_bin = 0; m_pos = 0; m_dir = 0;
    m_sv = 0; m_er = 0; m_errc = 0; m_trk = 0; m_stable = 0; m_last = 0;
  endtask

  task automatic model_edge();
    int s, b, d;
    bit v;
    s = m_pipe[SS-1];
    v = (m_fill >= SS);
    b = g2b(s);
    m_sv = 0;
    m_er = 0;
    if (bus.clr) begin
      m_pos = 0; m_errc = 0; m_dir = 0; m_mode = 0; m_stable = 0;
    end else if (bus.en) begin
      if (m_mode == 0) begin
        if (v) begin
          m_prev_b = b; m_bin = b; m_pos = b; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        d = (b - m_prev_b + M) % M;
        if (d == 1) begin
          m_pos = (m_pos + 1) % 65536; m_dir = 1; m_sv = 1; m_prev_b = b; m_bin = b;
        end else if (d == M - 1) begin
          m_pos = (m_pos + 65535) % 65536; m_dir = 0; m_sv = 1; m_prev_b = b; m_bin = b;
        end else if (d != 0) begin
          m_er = 1;
          if (m_errc < 255) m_errc++;
          m_mode = 2; m_stable = 0; m_last = s;
        end
      end else begin
        if (s == m_last) begin
          m_stable++;
          if (m_stable == 4) begin
            m_prev_b = b; m_bin = b; m_mode = 1; m_stable = 0;
          end
        end else begin
          m_stable = 0; m_last = s;
        end
      end
    end
    m_trk = (m_mode == 1) ? 1 : 0;
    for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = int'(bus.g_in);
    if (m_fill < SS) m_fill++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.pos !== 16'h0) begin n_bad++; $display("FAIL reset_pos: got %h want 0000", bus.pos); end
    n_cmp++; if (bus.bin_out !== 4'h0) begin n_bad++; $display("FAIL reset_bin: got %b want 0000", bus.bin_out); end
    n_cmp++; if (bus.trk !== 1'b0) begin n_bad++; $display("FAIL reset_trk: got %b want 0", bus.trk); end
    n_cmp++; if (bus.err_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", bus.err_cnt); end
    n_cmp++; if (bus.step_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sv: got %b want 0", bus.step_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", bus.dir); end
  endtask

  task automatic test_init();
    bus.en = 1'b1; bus.clr = 1'b0; bus.g_in = 4'b0110;
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_cmp++; if (bus.trk !== 1'(e >= 3)) begin n_bad++; $display("FAIL init_trk_edge%0d: got %b want %b", e, bus.trk, e >= 3); end
      n_cmp++; if (bus.step_valid !== 1'b0) begin n_bad++; $display("FAIL init_sv_edge%0d: got %b want 0", e, bus.step_valid); end
    end
    n_cmp++; if (bus.pos !== 16'd4) begin n_bad++; $display("FAIL init_pos: got %0d want 4", bus.pos); end
    n_cmp++; if (bus.bin_out !== 4'b0100) begin n_bad++; $display("FAIL init_bin: got %b want 0100", bus.bin_out); end
    cur_b = 4;
  endtask

  task automatic test_steps();
    int grays[3] = '{4'b0111, 4'b0101, 4'b0100};
    int pulses;
    for (int i = 0; i < 3; i++) begin
      bus.g_in = 4'(grays[i]);
      for (int k = 1; k <= 4; k++) begin
        tick();
        n_cmp++; if (bus.step_valid !== 1'(k == 3)) begin n_bad++; $display("FAIL step_lat%0d_k%0d: got %b want %b", i, k, bus.step_valid, k == 3); end
      end
      n_cmp++; if (bus.pos !== 16'(5 + i)) begin n_bad++; $display("FAIL step_pos%0d: got %0d want %0d", i, bus.pos, 5 + i); end
      n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL step_dir%0d: got %b want 1", i, bus.dir); end
    end
    bus.g_in = 4'b0101;
    pulses = 0;
    repeat (4) begin tick(); if (bus.step_valid === 1'b1) pulses++; end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL rev_pulses: got %0d want 1", pulses); end
    n_cmp++; if (bus.pos !== 16'd6) begin n_bad++; $display("FAIL rev_pos: got %0d want 6", bus.pos); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL rev_dir: got %b want 0", bus.dir); end
    cur_b = 6;
  endtask

  task automatic test_code_wrap();
    for (int b = 7; b <= 15; b++) begin
      bus.g_in = 4'(b2g(b));
      repeat (3) tick();
      n_cmp++; if (bus.pos !== 16'(b)) begin n_bad++; $display("FAIL climb_pos%0d: got %0d want %0d", b, bus.pos, b); end
    end
    bus.g_in = 4'b0000;
    repeat (3) tick();
    n_cmp++; if (bus.step_valid !== 1'b1 || bus.dir !== 1'b1) begin n_bad++; $display("FAIL wrap_up: got sv=%b dir=%b want sv=1 dir=1", bus.step_valid, bus.dir); end
    n_cmp++; if (bus.bin_out !== 4'b0000 || bus.pos !== 16'd16) begin n_bad++; $display("FAIL wrap_up_val: got bin=%b pos=%0d want 0000/16", bus.bin_out, bus.pos); end
    bus.g_in = 4'b1000;
    repeat (3) tick();
    n_cmp++; if (bus.step_valid !== 1'b1 || bus.dir !== 1'b0) begin n_bad++; $display("FAIL wrap_dn: got sv=%b dir=%b want sv=1 dir=0", bus.step_valid, bus.dir); end
    n_cmp++; if (bus.bin_out !== 4'b1111 || bus.pos !== 16'd15) begin n_bad++; $display("FAIL wrap_dn_val: got bin=%b pos=%0d want 1111/15", bus.bin_out, bus.pos); end
    cur_b = 15;
  endtask

  task automatic test_error();
    bus.g_in = 4'b0000;
    repeat (4) tick();
    bus.g_in = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (bus.err !== 1'(k == 3)) begin n_bad++; $display("FAIL err_pulse_k%0d: got %b want %b", k, bus.err, k == 3); end
    end
    n_cmp++; if (bus.err_cnt !== 8'd1) begin n_bad++; $display("FAIL err_cnt1: got %0d want 1", bus.err_cnt); end
    n_cmp++; if (bus.pos !== 16'd16 || bus.trk !== 1'b0) begin n_bad++; $display("FAIL err_frozen: got pos=%0d trk=%b want 16/0", bus.pos, bus.trk); end
    for (int h = 1; h <= 4; h++) begin
      tick();
      n_cmp++; if (bus.trk !== 1'(h == 4)) begin n_bad++; $display("FAIL resync_trk_h%0d: got %b want %b", h, bus.trk, h == 4); end
      n_cmp++; if (bus.err !== 1'b0 || bus.step_valid !== 1'b0) begin n_bad++; $display("FAIL resync_quiet_h%0d: got err=%b sv=%b want 0/0", h, bus.err, bus.step_valid); end
    end
    n_cmp++; if (bus.bin_out !== 4'b0011 || bus.pos !== 16'd16) begin n_bad++; $display("FAIL resync_val: got bin=%b pos=%0d want 0011/16", bus.bin_out, bus.pos); end
    n_cmp++; if (mvec() !== {bus.bin_out, bus.pos, bus.dir, bus.step_valid, bus.err, bus.err_cnt, bus.trk}) begin
      n_bad++; $display("FAIL resync_model: got %h want %h", {bus.bin_out, bus.pos, bus.dir, bus.step_valid, bus.err, bus.err_cnt, bus.trk}, mvec());
    end
    cur_b = 3;
  endtask

  task automatic test_en_gating();
    bus.en = 1'b0;
    bus.g_in = 4'(b2g(4));
    repeat (5) begin
      tick();
      n_cmp++; if (bus.step_valid !== 1'b0 || bus.pos !== 16'd16) begin n_bad++; $display("FAIL en_hold: got sv=%b pos=%0d want 0/16", bus.step_valid, bus.pos); end
    end
    bus.en = 1'b1;
    tick();
    n_cmp++; if (bus.step_valid !== 1'b1 || bus.pos !== 16'd17 || bus.bin_out !== 4'd4) begin
      n_bad++; $display("FAIL en_release: got sv=%b pos=%0d bin=%0d want 1/17/4", bus.step_valid, bus.pos, bus.bin_out);
    end
    cur_b = 4;
  endtask

  task automatic test_err_saturation();
    int exp_cnt = 1;
    for (int i = 0; i < 260; i++) begin
      cur_b = (cur_b + 2) % M;
      bus.g_in = 4'(b2g(cur_b));
      repeat (3) tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      n_cmp++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'(exp_cnt)) begin
        n_bad++; $display("FAIL sat_err%0d: got err=%b cnt=%0d want 1/%0d", i, bus.err, bus.err_cnt, exp_cnt);
      end
      repeat (4) tick();
      n_cmp++; if (bus.trk !== 1'b1) begin n_bad++; $display("FAIL sat_resync%0d: got trk=%b want 1", i, bus.trk); end
    end
    n_cmp++; if (bus.err_cnt !== 8'd255 || bus.pos !== 16'd17) begin n_bad++; $display("FAIL sat_final: got cnt=%0d pos=%0d want 255/17", bus.err_cnt, bus.pos); end
  endtask

  task automatic test_pos_wrap();
    int n;
    n = 32767 - m_pos;
    for (int i = 0; i < n; i++) begin
      cur_b = (cur_b + 1) % M;
      bus.g_in = 4'(b2g(cur_b));
      tick();
    end
    repeat (3) tick();
    n_cmp++; if (bus.pos !== 16'h7FFF) begin n_bad++; $display("FAIL ramp_pos: got %h want 7fff", bus.pos); end
    cur_b = (cur_b + 1) % M;
    bus.g_in = 4'(b2g(cur_b));
    repeat (3) tick();
    n_cmp++; if (bus.pos !== 16'h8000 || bus.step_valid !== 1'b1) begin n_bad++; $display("FAIL pos_wrap_up: got pos=%h sv=%b want 8000/1", bus.pos, bus.step_valid); end
    cur_b = (cur_b + M - 1) % M;
    bus.g_in = 4'(b2g(cur_b));
    repeat (3) tick();
    n_cmp++; if (bus.pos !== 16'h7FFF || bus.dir !== 1'b0) begin n_bad++; $display("FAIL pos_wrap_dn: got pos=%h dir=%b want 7fff/0", bus.pos, bus.dir); end
  endtask

  task automatic test_clr_vs_step();
    cur_b = (cur_b + 1) % M;
    bus.g_in = 4'(b2g(cur_b));
    repeat (2) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_cmp++; if (bus.pos !== 16'h0 || bus.step_valid !== 1'b0 || bus.trk !== 1'b0) begin
      n_bad++; $display("FAIL clr_prio: got pos=%h sv=%b trk=%b want 0000/0/0", bus.pos, bus.step_valid, bus.trk);
    end
    n_cmp++; if (bus.err_cnt !== 8'h0 || bus.dir !== 1'b0) begin n_bad++; $display("FAIL clr_cnt: got cnt=%0d dir=%b want 0/0", bus.err_cnt, bus.dir); end
    tick();
    n_cmp++; if (bus.pos !== 16'(cur_b) || bus.bin_out !== 4'(cur_b) || bus.trk !== 1'b1 || bus.step_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_reinit: got pos=%0d bin=%0d trk=%b sv=%b want %0d/%0d/1/0", bus.pos, bus.bin_out, bus.trk, bus.step_valid, cur_b, cur_b);
    end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] got;
    for (int c = 0; c < 3000; c++) begin
      bus.en  = ($urandom_range(0, 7) != 0);
      bus.clr = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 9);
      if (r == 4 || r == 5) cur_b = (cur_b + 1) % M;
      else if (r == 6 || r == 7) cur_b = (cur_b + M - 1) % M;
      else if (r == 8) cur_b = $urandom_range(0, M - 1);
      bus.g_in = 4'(b2g(cur_b));
      tick();
      got = {bus.bin_out, bus.pos, bus.dir, bus.step_valid, bus.err, bus.err_cnt, bus.trk};
      n_cmp++; if (got !== mvec()) begin n_bad++; $display("FAIL rand_c%0d: got %h want %h", c, got, mvec()); end
    end
    bus.clr = 1'b0;
    bus.en  = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    #2;
    got = {bus.bin_out, bus.pos, bus.dir, bus.step_valid, bus.err, bus.err_cnt, bus.trk};
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL async_reset: got %h want 00000000", got); end
    model_reset();
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.g_in = '0;
    model_reset();
    test_reset();
    test_init();
    test_steps();
    test_code_wrap();
    test_error();
    test_en_gating();
    test_err_saturation();
    test_pos_wrap();
    test_clr_vs_step();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
